// File: rtl/copperv_read_arbiter.sv
// Round-robin arbiter sharing one memory read port between the fetch (i_*) and load (d_*) channels.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module copperv_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_raddr_valid,
    output logic                  i_raddr_ready,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                  i_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_raddr_valid,
    output logic                  d_raddr_ready,
    input  logic [ADDR_WIDTH-1:0] d_raddr,
    output logic                  d_rdata_valid,
    input  logic                  d_rdata_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_raddr_valid,
    input  logic                  m_raddr_ready,
    output logic [ADDR_WIDTH-1:0] m_raddr,
    input  logic                  m_rdata_valid,
    output logic                  m_rdata_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  err_unexpected
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           i_grant_cnt,
    output logic [31:0]           d_grant_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_W:0] MAX_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                     state;
    logic                       last_grant;
    logic                       pending_tag;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W:0]             count;

    logic grant_ok;
    logic pick_d;
    logic i_hs;
    logic d_hs;
    logic head;
    logic nonempty;
    logic push;
    logic pop;

    // Tag 0 is the fetch channel, 1 the load channel; when both ask, the one not granted last wins.
    assign grant_ok      = (state == IDLE) && (count < MAX_CNT);
    assign pick_d        = d_raddr_valid && (!i_raddr_valid || !last_grant);
    assign i_raddr_ready = grant_ok && i_raddr_valid && !pick_d;
    assign d_raddr_ready = grant_ok && pick_d;
    assign i_hs          = i_raddr_valid && i_raddr_ready;
    assign d_hs          = d_raddr_valid && d_raddr_ready;

    assign nonempty      = (count != '0);
    assign head          = tag_mem[rd_ptr];
    assign i_rdata_valid = nonempty && m_rdata_valid && !head;
    assign d_rdata_valid = nonempty && m_rdata_valid && head;
    assign m_rdata_ready = nonempty && (head ? d_rdata_ready : i_rdata_ready);
    assign i_rdata       = m_rdata;
    assign d_rdata       = m_rdata;

    assign push = m_raddr_valid && m_raddr_ready;
    assign pop  = m_rdata_valid && m_rdata_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            pending_tag   <= 1'b0;
            m_raddr       <= '0;
            m_raddr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_hs || d_hs) begin
                        m_raddr       <= d_hs ? d_raddr : i_raddr;
                        pending_tag   <= d_hs;
                        last_grant    <= d_hs;
                        m_raddr_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_raddr_ready) begin
                        m_raddr_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-order owner FIFO; grants stop at MAX_OUTSTANDING so a push never finds it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_mem        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= pending_tag;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!nonempty && m_rdata_valid) begin
                err_unexpected <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (i_hs && i_grant_cnt != '1) begin
                i_grant_cnt <= i_grant_cnt + 1'b1;
            end
            if (d_hs && d_grant_cnt != '1) begin
                d_grant_cnt <= d_grant_cnt + 1'b1;
            end
            if ((i_raddr_valid || d_raddr_valid) && !(i_hs || d_hs) && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_copperv_read_arbiter.sv
// Randomized and directed bench for copperv_read_arbiter against a queue-based reference model.
module tb_copperv_read_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
    logic [31:0] i_raddr, i_rdata;
    logic        d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
    logic [31:0] d_raddr, d_rdata;
    logic        m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
    logic [31:0] m_raddr, m_rdata;
    logic        err_unexpected;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] i_grant_cnt, d_grant_cnt, stall_cnt;
`endif

    copperv_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
        .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
        .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
        .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
        .m_raddr_valid(m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(m_raddr),
        .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata),
        .err_unexpected(err_unexpected)
`ifdef ARB_PERF_CNT_EN
        , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus policy
    bit rnd, mem_rdy, mem_rsp, i_rdy, d_rdy, stale;
    logic [31:0] i_src[$], d_src[$];
    logic [31:0] mem[logic [31:0]];

    // Reference model: requests in flight are described purely by queues of owners and addresses
    bit          busy, busy_tag, last_d, err_exp, mv_hold;
    logic [31:0] busy_addr;
    bit          tag_q[$];
    logic [31:0] addr_q[$], i_exp_q[$], d_exp_q[$];
    logic [31:0] mraddr_log[$], i_rx_log[$], d_rx_log[$];
    int          grants, i_ready_seen, stall_seen;
    logic [31:0] m_i_cnt, m_d_cnt, m_stall;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic model_clear();
        busy = 0; busy_tag = 0; busy_addr = '0; last_d = 1; err_exp = 0; mv_hold = 0;
        tag_q.delete(); addr_q.delete(); i_exp_q.delete(); d_exp_q.delete();
        mraddr_log.delete(); i_rx_log.delete(); d_rx_log.delete();
        grants = 0; i_ready_seen = 0; stall_seen = 0;
        m_i_cnt = '0; m_d_cnt = '0; m_stall = '0;
    endtask

    // One clock cycle: drive at negedge, compare mid-cycle, advance the model at posedge.
    task automatic applyStimulus();
        int count;
        bit gok, win_d, h, exp_ir, exp_dr, exp_iv, exp_dv, exp_mr, pop, ihs, dhs;
        logic [31:0] mraddr_now, irdata_now, drdata_now;
        if (rnd) begin
            if (i_src.size() == 0 && $urandom_range(0, 2) == 0) i_src.push_back($urandom & 32'hFFFF_FFFC);
            if (d_src.size() == 0 && $urandom_range(0, 2) == 0) d_src.push_back($urandom & 32'hFFFF_FFFC);
            mem_rdy = ($urandom_range(0, 3) != 0);
            mem_rsp = ($urandom_range(0, 2) != 0);
            i_rdy   = ($urandom_range(0, 3) != 0);
            d_rdy   = ($urandom_range(0, 3) != 0);
        end
        i_raddr_valid = (i_src.size() > 0);
        i_raddr       = i_raddr_valid ? i_src[0] : 32'h0;
        d_raddr_valid = (d_src.size() > 0);
        d_raddr       = d_raddr_valid ? d_src[0] : 32'h0;
        m_raddr_ready = mem_rdy;
        i_rdata_ready = i_rdy;
        d_rdata_ready = d_rdy;
        if (stale) begin
            m_rdata_valid = 1'b1;
            m_rdata       = 32'hDEAD_BEEF;
        end else if (addr_q.size() > 0 && (mv_hold || mem_rsp)) begin
            m_rdata_valid = 1'b1;
            m_rdata       = mem_data(addr_q[0]);
        end else begin
            m_rdata_valid = 1'b0;
            m_rdata       = $urandom;
        end
        #2;
        count  = tag_q.size();
        gok    = !busy && (count < MAXO);
        win_d  = (i_raddr_valid && d_raddr_valid) ? !last_d : d_raddr_valid;
        exp_ir = gok && i_raddr_valid && !win_d;
        exp_dr = gok && d_raddr_valid && win_d;
        h      = (count > 0) ? tag_q[0] : 1'b0;
        exp_iv = (count > 0) && m_rdata_valid && !h;
        exp_dv = (count > 0) && m_rdata_valid && h;
        exp_mr = (count > 0) && (h ? d_rdata_ready : i_rdata_ready);
        checkOutput("i_raddr_ready", i_raddr_ready, exp_ir);
        checkOutput("d_raddr_ready", d_raddr_ready, exp_dr);
        checkOutput("m_raddr_valid", m_raddr_valid, busy);
        if (busy) checkOutput("m_raddr", m_raddr, busy_addr);
        checkOutput("i_rdata_valid", i_rdata_valid, exp_iv);
        checkOutput("d_rdata_valid", d_rdata_valid, exp_dv);
        checkOutput("m_rdata_ready", m_rdata_ready, exp_mr);
        if (exp_iv) checkOutput("i_rdata", i_rdata, mem_data(i_exp_q[0]));
        if (exp_dv) checkOutput("d_rdata", d_rdata, mem_data(d_exp_q[0]));
        checkOutput("err_unexpected", err_unexpected, err_exp);
`ifdef ARB_PERF_CNT_EN
        checkOutput("i_grant_cnt", i_grant_cnt, m_i_cnt);
        checkOutput("d_grant_cnt", d_grant_cnt, m_d_cnt);
        checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
        if (i_raddr_valid && i_raddr_ready) i_ready_seen++;
        if (i_rdata_valid && !m_rdata_ready) stall_seen++;
        mraddr_now = m_raddr;
        irdata_now = i_rdata;
        drdata_now = d_rdata;
        @(posedge clk);
        pop = m_rdata_valid && exp_mr;
        ihs = exp_ir && i_raddr_valid;
        dhs = exp_dr && d_raddr_valid;
        if (count == 0 && m_rdata_valid) err_exp = 1;
        if (pop) begin
            void'(tag_q.pop_front());
            void'(addr_q.pop_front());
            if (h) begin void'(d_exp_q.pop_front()); d_rx_log.push_back(drdata_now); end
            else   begin void'(i_exp_q.pop_front()); i_rx_log.push_back(irdata_now); end
            mv_hold = 0;
        end else begin
            mv_hold = m_rdata_valid && !stale;
        end
        if (busy && m_raddr_ready) begin
            tag_q.push_back(busy_tag);
            addr_q.push_back(busy_addr);
            mraddr_log.push_back(mraddr_now);
            busy = 0;
        end
        if (ihs || dhs) begin
            busy      = 1;
            busy_tag  = dhs;
            last_d    = dhs;
            busy_addr = dhs ? d_src.pop_front() : i_src.pop_front();
            if (dhs) d_exp_q.push_back(busy_addr); else i_exp_q.push_back(busy_addr);
            grants++;
        end
        if (ihs && m_i_cnt != '1) m_i_cnt++;
        if (dhs && m_d_cnt != '1) m_d_cnt++;
        if ((i_raddr_valid || d_raddr_valid) && !(ihs || dhs) && m_stall != '1) m_stall++;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        i_src.delete(); d_src.delete();
        rnd = 0; mem_rdy = 0; mem_rsp = 0; i_rdy = 0; d_rdy = 0; stale = 0;
        i_raddr_valid = 0; d_raddr_valid = 0; i_raddr = '0; d_raddr = '0;
        i_rdata_ready = 0; d_rdata_ready = 0; m_raddr_ready = 0; m_rdata_valid = 0; m_rdata = '0;
        #2;
        checkOutput("rst_m_raddr", m_raddr, 32'h0);
        checkOutput("rst_m_raddr_valid", m_raddr_valid, 1'b0);
        checkOutput("rst_err", err_unexpected, 1'b0);
        checkOutput("rst_i_raddr_ready", i_raddr_ready, 1'b0);
        checkOutput("rst_d_raddr_ready", d_raddr_ready, 1'b0);
        checkOutput("rst_i_rdata_valid", i_rdata_valid, 1'b0);
        checkOutput("rst_d_rdata_valid", d_rdata_valid, 1'b0);
        checkOutput("rst_m_rdata_ready", m_rdata_ready, 1'b0);
`ifdef ARB_PERF_CNT_EN
        checkOutput("rst_i_grant_cnt", i_grant_cnt, 32'h0);
        checkOutput("rst_d_grant_cnt", d_grant_cnt, 32'h0);
        checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [31:0] exp_seq[4];
        exp_seq = '{32'h200, 32'h800, 32'h200, 32'h800};
        mem[32'h100] = 32'h0000_0013;
        mem[32'h10]  = 32'hA;
        mem[32'h20]  = 32'hB;
        mem[32'h14]  = 32'hC;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        doReset();

        $display("[TB] single fetch");
        mem_rdy = 1; mem_rsp = 1; i_rdy = 1; d_rdy = 1;
        i_src.push_back(32'h100);
        for (int c = 0; c < 8; c++) applyStimulus();
        checkOutput("fetch_rx_count", i_rx_log.size(), 1);
        if (i_rx_log.size() > 0) checkOutput("fetch_rx_data", i_rx_log[0], 32'h13);
        checkOutput("fetch_d_rx_count", d_rx_log.size(), 0);

        $display("[TB] contention");
        doReset();
        mem_rdy = 1; mem_rsp = 1; i_rdy = 1; d_rdy = 1;
        for (int c = 0; c < 100 && grants < 10; c++) begin
            if (i_src.size() == 0) i_src.push_back(32'h200);
            if (d_src.size() == 0) d_src.push_back(32'h800);
            applyStimulus();
        end
        checkOutput("contention_grants", grants, 10);
        checkOutput("contention_pushes", mraddr_log.size() >= 4, 1'b1);
        for (int k = 0; k < 4 && k < mraddr_log.size(); k++)
            checkOutput($sformatf("contention_m_raddr%0d", k), mraddr_log[k], exp_seq[k]);
`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_i_grants", i_grant_cnt, 32'd5);
        checkOutput("perf_d_grants", d_grant_cnt, 32'd5);
        checkOutput("perf_stalls", stall_cnt, m_stall);
`endif

        $display("[TB] in-order routing");
        doReset();
        mem_rdy = 1; mem_rsp = 1; i_rdy = 1; d_rdy = 1;
        i_src.push_back(32'h10); i_src.push_back(32'h14); d_src.push_back(32'h20);
        for (int c = 0; c < 15; c++) applyStimulus();
        checkOutput("order_i_count", i_rx_log.size(), 2);
        checkOutput("order_d_count", d_rx_log.size(), 1);
        if (i_rx_log.size() > 1) begin
            checkOutput("order_i0", i_rx_log[0], 32'hA);
            checkOutput("order_i1", i_rx_log[1], 32'hC);
        end
        if (d_rx_log.size() > 0) checkOutput("order_d0", d_rx_log[0], 32'hB);

        $display("[TB] full fifo");
        doReset();
        mem_rdy = 1; mem_rsp = 0; i_rdy = 1; d_rdy = 1;
        for (int k = 0; k < 5; k++) i_src.push_back(32'h40 + 32'(4 * k));
        for (int c = 0; c < 12; c++) applyStimulus();
        checkOutput("full_grants_held", i_ready_seen, 4);
        mem_rsp = 1;
        for (int c = 0; c < 6; c++) applyStimulus();
        checkOutput("full_fifth_granted", i_ready_seen, 5);

        $display("[TB] backpressure and reset");
        doReset();
        mem_rdy = 1; mem_rsp = 1; i_rdy = 0; d_rdy = 1;
        i_src.push_back(32'h60); i_src.push_back(32'h64);
        for (int c = 0; c < 7; c++) applyStimulus();
        checkOutput("bp_stall_cycles", stall_seen >= 3, 1'b1);
        checkOutput("bp_outstanding", i_ready_seen, 2);
        doReset();
        stale = 1;
        applyStimulus();
        stale = 0;
        applyStimulus();
        checkOutput("stale_err", err_unexpected, 1'b1);

        $display("[TB] random");
        doReset();
        rnd = 1;
        for (int c = 0; c < 3000; c++) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/copperv_read_arbiter.md
Name: copperv_read_arbiter

Overview:
- Shares one memory read port between the copperv instruction-fetch read channel (i_*) and the data-load read channel (d_*).
- Arbitrates address requests round-robin and records the owner of each issued request in an in-order tag FIFO.
- Steers each memory response back to the channel that issued it.
- Sits between the CPU core bus ports and the single-ported memory/bus model used in simulation and synthesis.

Parameters:
- ADDR_WIDTH, 32, width of all read addresses.
- DATA_WIDTH, 32, width of all read data.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered memory reads; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_raddr_valid  in  1  instruction fetch request valid.
- i_raddr_ready  out  1  instruction request accepted.
- i_raddr  in  ADDR_WIDTH  instruction fetch address.
- i_rdata_valid  out  1  instruction data valid.
- i_rdata_ready  in  1  core ready for instruction data.
- i_rdata  out  DATA_WIDTH  instruction data.
- d_raddr_valid / d_raddr_ready / d_raddr  in / out / in  1 / 1 / ADDR_WIDTH  data load request channel.
- d_rdata_valid / d_rdata_ready / d_rdata  out / in / out  DATA_WIDTH for data  data load response channel.
- m_raddr_valid  out  1  memory request valid.
- m_raddr_ready  in  1  memory accepts request.
- m_raddr  out  ADDR_WIDTH  memory request address (registered).
- m_rdata_valid  in  1  memory response valid.
- m_rdata_ready  out  1  arbiter accepts response.
- m_rdata  in  DATA_WIDTH  memory response data.
- err_unexpected  out  1  sticky: response arrived with no outstanding request.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; tag FIFO is emptied (count=0).
  - last_grant=D, so I wins the first contested cycle.
  - m_raddr=0, m_raddr_valid=0, err_unexpected=0; all ready/valid outputs are 0.
- Handshake rule: a transfer occurs on a posedge where valid && ready. Valid, once asserted, holds with stable payload until the transfer. Ready may depend combinationally on valid.
- Address FSM, two states:
  - IDLE:
    - grant_ok = (count < MAX_OUTSTANDING).
    - Winner selection: if both valid, winner = channel != last_grant; otherwise the single valid channel.
    - The winner's x_raddr_ready = grant_ok (combinational); the loser's ready = 0.
    - On handshake: m_raddr <= winner address, pending_tag <= winner (0=I, 1=D), last_grant <= winner, go to ISSUE.
  - ISSUE:
    - m_raddr_valid = 1; both x_raddr_ready = 0.
    - On m_raddr_ready: push pending_tag into the tag FIFO, go to IDLE.
- Timing: latency from CPU handshake to m_raddr_valid is 1 cycle. Peak throughput is one request per 2 cycles.
- Capacity: grant only in IDLE with count < MAX_OUTSTANDING, so a push never overflows. Count update: +1 on push, -1 on pop; simultaneous push and pop leaves count unchanged.
- Response routing (combinational, FIFO head tag h):
  - When count > 0:
    - i_rdata_valid = m_rdata_valid && h==0.
    - d_rdata_valid = m_rdata_valid && h==1.
    - m_rdata_ready = the owner's x_rdata_ready.
    - i_rdata = d_rdata = m_rdata (unconditionally).
  - Pop the head on the m_rdata handshake.
  - Backpressure: the non-owner channel never sees valid. A stalled owner blocks the memory response; responses are strictly in order.
- Empty FIFO:
  - m_rdata_ready = 0; no x_rdata_valid.
  - If m_rdata_valid=1, set err_unexpected (sticky until reset).
- Reset mid-operation: in-flight requests are discarded. Responses to pre-reset requests that arrive after reset set err_unexpected.
- Tag FIFO: depth MAX_OUTSTANDING, 1-bit entries, read/write pointers of width log2(MAX_OUTSTANDING) that wrap naturally.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs i_grant_cnt, d_grant_cnt (32-bit each): incremented on each x_raddr handshake.
  - Adds output stall_cnt (32-bit): incremented each cycle any x_raddr_valid=1 with no handshake.
  - All counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single fetch:
  - Stimulus: i_raddr=0x100 valid, m_raddr_ready=1, memory answers 0x00000013 two cycles later.
  - Required: m_raddr=0x100 one cycle after the handshake; i_rdata=0x00000013 with i_rdata_valid; d_rdata_valid never 1.
- Contention:
  - Stimulus: I and D both valid continuously after reset, addresses 0x200 and 0x800.
  - Required: grants ordered I,D,I,D; m_raddr sequence 0x200,0x800,0x200,0x800.
- In-order routing:
  - Stimulus: issue I(0x10), D(0x20), I(0x14); memory returns 0xA,0xB,0xC.
  - Required: I receives 0xA then 0xC; D receives 0xB.
- Full FIFO:
  - Stimulus: MAX_OUTSTANDING=4, four requests issued, memory withholds responses, a fifth I request is held valid.
  - Required: i_raddr_ready stays 0 until the first response pops, then the fifth request is granted.
- Backpressure and reset:
  - Stimulus: owner x_rdata_ready=0 for 3 cycles; then rst pulse with 2 outstanding, followed by one stale m_rdata_valid.
  - Required: m_rdata_ready=0 during the stall and data is held. After reset: count=0 and all outputs are 0; the stale response then sets err_unexpected=1.
- ARB_PERF_CNT_EN:
  - Stimulus: the contention test for 10 grants.
  - Required: i_grant_cnt=5, d_grant_cnt=5; stall_cnt equals the number of cycles with a pending, ungranted request.
